// File: rtl/decode_regfile.sv
// Y86-64 decode stage: field decode, 15 x DATA_W register file, operand forwarding.
// Define DECODE_FWD_EN for the full e/M/m/W forwarding chain; otherwise only a W-stage write bypass.
module decode_regfile #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        d_dstE,
  output logic [3:0]        d_dstM,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  logic [DATA_W-1:0] regs [0:14];

`ifndef DECODE_FWD_EN
  // Execute/memory terms are not consulted here; hazard control stalls on them instead.
  logic unused_fwd;
  assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM};
`endif

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      4'h2: begin d_srcA = D_rA; d_dstE = D_rB; end
      4'h3: begin d_dstE = D_rB; end
      4'h4: begin d_srcA = D_rA; d_srcB = D_rB; end
      4'h5: begin d_srcB = D_rB; d_dstM = D_rA; end
      4'h6: begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      4'h8: begin d_srcB = RSP;  d_dstE = RSP; end
      4'h9: begin d_srcA = RSP;  d_srcB = RSP; d_dstE = RSP; end
      4'hA: begin d_srcA = D_rA; d_srcB = RSP; d_dstE = RSP; end
      4'hB: begin d_srcA = RSP;  d_srcB = RSP; d_dstE = RSP; d_dstM = D_rA; end
      default: ;
    endcase
  end

  // Youngest producer wins; W_valM outranks W_valE so popq %rsp reads the popped value.
  function automatic logic [DATA_W-1:0] operand(input logic [3:0] src);
    logic [DATA_W-1:0] val;
    if (src == RNONE)                          val = '0;
`ifdef DECODE_FWD_EN
    else if (e_dstE != RNONE && src == e_dstE) val = e_valE;
    else if (M_dstM != RNONE && src == M_dstM) val = m_valM;
    else if (M_dstE != RNONE && src == M_dstE) val = M_valE;
`endif
    else if (W_dstM != RNONE && src == W_dstM) val = W_valM;
    else if (W_dstE != RNONE && src == W_dstE) val = W_valE;
    else                                       val = regs[src];
    return val;
  endfunction

  always_comb begin
    d_valA = '0;
    d_valB = '0;
    if (D_icode == 4'h7 || D_icode == 4'h8) d_valA = D_valP;
    else                                    d_valA = operand(d_srcA);
    d_valB = operand(d_srcB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= (i == 4) ? RSP_RESET : '0;
    end else begin
      if (W_dstE != RNONE) regs[W_dstE] <= W_valE;
      if (W_dstM != RNONE) regs[W_dstM] <= W_valM;
    end
  end

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: per-cycle model comparison plus hand-computed spot checks.
module tb_decode_regfile;

  localparam logic [63:0] RSPV = 64'h1000;

  logic        clk, rst_n;
  logic [3:0]  D_icode, D_rA, D_rB, e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] D_valP, e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB;

  int checks = 0;
  int errors = 0;
  bit run = 0;
  logic [63:0] mregs [0:15];

  decode_regfile #(.DATA_W(64), .RSP_RESET(RSPV)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .D_rA(D_rA), .D_rB(D_rB), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valA(d_valA), .d_valB(d_valB)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural register state as seen by the model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mregs[i] <= 64'h0;
      mregs[4] <= RSPV;
    end else begin
      if (W_dstE != 4'hF) mregs[W_dstE] <= W_valE;
      if (W_dstM != 4'hF) mregs[W_dstM] <= W_valM;
    end
  end

  function automatic logic [15:0] exp_dec(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    logic [3:0] sa, sb, de, dm;
    sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    de = (ic inside {4'h2, 4'h3, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    dm = (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    return {sa, sb, de, dm};
  endfunction

  // Candidate producers listed youngest first; first non-RNONE match supplies the value.
  function automatic logic [63:0] exp_val(input logic [3:0] src, input bit use_valp);
    logic [3:0]  dq [$];
    logic [63:0] vq [$];
    if (use_valp) return D_valP;
    if (src == 4'hF) return 64'h0;
`ifdef DECODE_FWD_EN
    dq.push_back(e_dstE); vq.push_back(e_valE);
    dq.push_back(M_dstM); vq.push_back(m_valM);
    dq.push_back(M_dstE); vq.push_back(M_valE);
`endif
    dq.push_back(W_dstM); vq.push_back(W_valM);
    dq.push_back(W_dstE); vq.push_back(W_valE);
    foreach (dq[i]) if (dq[i] != 4'hF && dq[i] == src) return vq[i];
    return mregs[src];
  endfunction

  always @(negedge clk) begin
    if (run) begin
      logic [15:0] e;
      e = exp_dec(D_icode, D_rA, D_rB);
      check("m_srcA", {60'h0, d_srcA}, {60'h0, e[15:12]});
      check("m_srcB", {60'h0, d_srcB}, {60'h0, e[11:8]});
      check("m_dstE", {60'h0, d_dstE}, {60'h0, e[7:4]});
      check("m_dstM", {60'h0, d_dstM}, {60'h0, e[3:0]});
      check("m_valA", d_valA, exp_val(e[15:12], D_icode inside {4'h7, 4'h8}));
      check("m_valB", d_valB, exp_val(e[11:8], 1'b0));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0;
    D_icode = 4'h1; D_rA = 4'hF; D_rB = 4'hF; D_valP = 64'h0;
    e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    clear_fwd();
    tick(); tick();
    rst_n = 1;
    run = 1;
    #1;
    check("nop_srcA", {60'h0, d_srcA}, 64'hF);
    check("nop_dstE", {60'h0, d_dstE}, 64'hF);
    check("nop_valA", d_valA, 64'h0);

    // Async reset mid-cycle wipes reg0 and restores %rsp.
    W_dstE = 4'h0; W_valE = 64'h5;
    tick();
    W_dstE = 4'hF; D_icode = 4'h2; D_rA = 4'h0; D_rB = 4'h1;
    #1 check("reg0_written", d_valA, 64'h5);
    rst_n = 0;
    #1 check("rst_async_reg0", d_valA, 64'h0);
    D_icode = 4'hA; D_rA = 4'h4;
    #1 check("rst_rsp", d_valA, RSPV);
    D_icode = 4'h2; D_rA = 4'h0; W_dstE = 4'h0; W_valE = 64'h7;
    tick();
    W_dstE = 4'hF;
    #1 check("no_wr_in_rst", d_valA, 64'h0);
    rst_n = 1;
    #1 check("after_rst_reg0", d_valA, 64'h0);

    // Write then read.
    W_dstE = 4'h3; W_valE = 64'h1234;
    tick();
    W_dstE = 4'hF; D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h7;
    #1;
    check("wr_srcA", {60'h0, d_srcA}, 64'h3);
    check("wr_valA", d_valA, 64'h1234);
    check("wr_dstE", {60'h0, d_dstE}, 64'h7);

    // Forwarding priority on srcA=2.
    D_icode = 4'h2; D_rA = 4'h2; D_rB = 4'h1;
    e_dstE = 4'h2; e_valE = 64'hAA; M_dstE = 4'h2; M_valE = 64'hBB; W_dstE = 4'h2; W_valE = 64'hCC;
`ifdef DECODE_FWD_EN
    #1 check("fwd_e", d_valA, 64'hAA);
    e_dstE = 4'hF;
    #1 check("fwd_M", d_valA, 64'hBB);
    M_dstM = 4'h2; m_valM = 64'hDD;
    #1 check("fwd_m", d_valA, 64'hDD);
`else
    #1 check("byp_W", d_valA, 64'hCC);
    e_dstE = 4'hF; M_dstM = 4'h2; m_valM = 64'hDD;
    #1 check("byp_W2", d_valA, 64'hCC);
`endif
    tick();
    clear_fwd();
    #1 check("reg2_cc", d_valA, 64'hCC);

    // popq %rsp: valM wins both in bypass and in the register.
    W_dstE = 4'h4; W_valE = 64'h108; W_dstM = 4'h4; W_valM = 64'h55;
    D_icode = 4'hA; D_rA = 4'h4;
    #1 check("popq_byp", d_valA, 64'h55);
    tick();
    clear_fwd();
    #1 check("popq_reg", d_valA, 64'h55);

    // call.
    W_dstE = 4'h4; W_valE = 64'h200;
    tick();
    W_dstE = 4'hF; D_icode = 4'h8; D_valP = 64'h40;
    #1;
    check("call_valA", d_valA, 64'h40);
    check("call_srcB", {60'h0, d_srcB}, 64'h4);
    check("call_valB", d_valB, 64'h200);
    check("call_dstE", {60'h0, d_dstE}, 64'h4);
    check("call_dstM", {60'h0, d_dstM}, 64'hF);

    // RNONE writes are dropped.
    W_dstE = 4'hF; W_valE = 64'hDEAD;
    tick();
    D_icode = 4'h2; D_rA = 4'hF;
    #1;
    check("rnone_srcA", {60'h0, d_srcA}, 64'hF);
    check("rnone_valA", d_valA, 64'h0);
    D_icode = 4'h6; D_rA = 4'h0; D_rB = 4'h3;
    #1;
    check("rnone_reg0", d_valA, 64'h0);
    check("rnone_reg3", d_valB, 64'h1234);

    // Sweep all icodes with assorted writes; the per-cycle model covers these.
    for (int i = 0; i < 16; i++) begin
      D_icode = i[3:0]; D_rA = 4'h1; D_rB = 4'h2; D_valP = 64'h100 + i;
      W_dstE = i[3:0]; W_valE = 64'h11 * i;
      W_dstM = (i % 3 == 0) ? 4'h1 : 4'hF; W_valM = 64'h9000 + i;
      e_dstE = (i % 2 == 0) ? 4'h2 : 4'hF; e_valE = 64'hE000 + i;
      M_dstE = 4'h1; M_valE = 64'hA000 + i;
      tick();
    end
    clear_fwd();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
